// File: rtl/fdiv_pkg.sv
// ---------------------------------------------------------------------------
// fdiv_pkg : shared constants, state encoding and helpers for seq_fdiv
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fdiv_pkg;

  localparam int DEF_EXP = 5;
  localparam int DEF_FRA = 10;

  function automatic int bias_of(input int exp_w);
    return 2 ** (exp_w - 1) - 1;
  endfunction

  function automatic int exp_max_of(input int exp_w);
    return 2 ** exp_w - 1;
  endfunction

  function automatic int iter_of(input int fra_w);
    return fra_w + 4;
  endfunction

  // Quiet NaN fraction: leading one followed by zeros
  function automatic int qnan_frac_of(input int fra_w);
    return 1 << (fra_w - 1);
  endfunction

  localparam int BIAS    = bias_of(DEF_EXP);
  localparam int EXP_MAX = exp_max_of(DEF_EXP);
  localparam int ITER    = iter_of(DEF_FRA);

  // Flag bit positions, shared with the multiplier
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_NAN  = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SPEC = 3'd1,
    ST_DIV  = 3'd2,
    ST_NORM = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fdiv_round.sv
// ---------------------------------------------------------------------------
// fdiv_round : normalizes the raw quotient, rounds to nearest-even and
//              resolves exponent overflow/underflow into the packed result
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fdiv_round
  import fdiv_pkg::*;
#(
  parameter int EXP = 5,
  parameter int FRA = 10
) (
  input  logic             sign,
  input  logic [FRA+3:0]   quo,
  input  logic [FRA+1:0]   rem,
  input  logic [EXP+1:0]   e_base,
  output logic [EXP+FRA:0] y,
  output logic [2:0]       flag
);

  localparam int QW   = FRA + 4;
  localparam int EW   = EXP + 2;
  localparam int EMAX = exp_max_of(EXP);

  logic [FRA-1:0] frac_raw;
  logic           guard;
  logic           sticky;
  logic           inc;
  logic [FRA:0]   frac_sum;
  logic [EW-1:0]  e_val;
  logic [EXP-1:0] expo_out;
  logic [FRA-1:0] frac_out;

  always_comb begin
    if (quo[QW-1]) begin
      frac_raw = quo[QW-2:3];
      guard    = quo[2];
      sticky   = (|quo[1:0]) | (|rem);
      e_val    = e_base;
    end else begin
      frac_raw = quo[QW-3:2];
      guard    = quo[1];
      sticky   = quo[0] | (|rem);
      e_val    = e_base - EW'(1);
    end

    inc      = guard & (sticky | frac_raw[0]);
    // Hidden bit is always one, so a carry out of the fraction is a renormalize
    frac_sum = {1'b0, frac_raw} + (FRA+1)'(inc);
    e_val    = e_val + EW'(frac_sum[FRA]);

    flag     = '0;
    expo_out = e_val[EXP-1:0];
    frac_out = frac_sum[FRA-1:0];
    if (!e_val[EW-1] && (e_val >= EW'(EMAX))) begin
      expo_out       = '1;
      frac_out       = '0;
      flag[FLAG_INF] = 1'b1;
    end else if (e_val[EW-1] || (e_val == '0)) begin
      expo_out        = '0;
      frac_out        = '0;
      flag[FLAG_ZERO] = 1'b1;
    end
  end

  fp_pack #(.EXP(EXP), .FRA(FRA)) u_pack (
    .sign (sign),
    .expo (expo_out),
    .frac (frac_out),
    .y    (y)
  );

endmodule

`default_nettype wire

// File: rtl/fp_pack.sv
// ---------------------------------------------------------------------------
// fp_pack : assembles a packed {sign, expo, frac} word
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_pack #(
  parameter int EXP = 5,
  parameter int FRA = 10
) (
  input  logic             sign,
  input  logic [EXP-1:0]   expo,
  input  logic [FRA-1:0]   frac,
  output logic [EXP+FRA:0] y
);

  assign y = {sign, expo, frac};

endmodule

`default_nettype wire

// File: rtl/fp_unpack.sv
// ---------------------------------------------------------------------------
// fp_unpack : splits a packed {sign, expo, frac} word and classifies it
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_unpack #(
  parameter int EXP = 5,
  parameter int FRA = 10
) (
  input  logic [EXP+FRA:0] x,
  output logic             sign,
  output logic [EXP-1:0]   expo,
  output logic [FRA-1:0]   frac,
  output logic             is_zero,
  output logic             is_inf,
  output logic             is_nan
);

  assign sign    = x[EXP+FRA];
  assign expo    = x[EXP+FRA-1:FRA];
  assign frac    = x[FRA-1:0];
  // Subnormals (expo == 0) are treated as zero
  assign is_zero = (expo == '0);
  assign is_inf  = (&expo) && (frac == '0);
  assign is_nan  = (&expo) && (frac != '0);

endmodule

`default_nettype wire

// File: rtl/seq_fdiv.sv
// ---------------------------------------------------------------------------
// seq_fdiv : sequential floating-point divider Y = A / B, radix-2 restoring
//            mantissa loop with valid/ready handshakes on both sides
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_fdiv
  import fdiv_pkg::*;
#(
  parameter int EXP = DEF_EXP,
  parameter int FRA = DEF_FRA
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP+FRA:0] A,
  input  logic [EXP+FRA:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP+FRA:0] Y,
  output logic [2:0]       flag
);

  localparam int W     = EXP + FRA + 1;
  localparam int SW    = FRA + 1;
  localparam int RW    = FRA + 2;
  localparam int QW    = FRA + 4;
  localparam int EW    = EXP + 2;
  localparam int CW    = $clog2(QW);
  localparam int LBIAS = bias_of(EXP);
  localparam int LITER = iter_of(FRA);
  localparam logic [FRA-1:0] QNAN_FRAC = FRA'(qnan_frac_of(FRA));

  logic           a_sign, b_sign;
  logic [EXP-1:0] a_expo, b_expo;
  logic [FRA-1:0] a_frac, b_frac;
  logic           a_zero, a_inf, a_nan;
  logic           b_zero, b_inf, b_nan;

  fp_unpack #(.EXP(EXP), .FRA(FRA)) u_unpack_a (
    .x (A), .sign (a_sign), .expo (a_expo), .frac (a_frac),
    .is_zero (a_zero), .is_inf (a_inf), .is_nan (a_nan)
  );

  fp_unpack #(.EXP(EXP), .FRA(FRA)) u_unpack_b (
    .x (B), .sign (b_sign), .expo (b_expo), .frac (b_frac),
    .is_zero (b_zero), .is_inf (b_inf), .is_nan (b_nan)
  );

  state_e         state_q, state_d;
  logic           sign_q, sign_d;
  logic [EXP-1:0] ea_q, ea_d, eb_q, eb_d;
  logic [SW-1:0]  mb_q, mb_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic [QW-1:0]  quo_q, quo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     spec_q, spec_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   y_q, y_d;
  logic [2:0]     flag_q, flag_d;

  logic [2:0]     spec_dec;
  logic [EW-1:0]  e_base;
  logic [W-1:0]   rnd_y, spec_y;
  logic [2:0]     rnd_flag;
  logic           sp_sign;
  logic [EXP-1:0] sp_expo;
  logic [FRA-1:0] sp_frac;
  logic           q_bit;
  logic [RW-1:0]  rem_sub;

  // Special-case decode in priority order NaN > infinity > zero
  always_comb begin
    spec_dec = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      spec_dec[FLAG_NAN] = 1'b1;
    else if (a_inf || b_zero)
      spec_dec[FLAG_INF] = 1'b1;
    else if (a_zero || b_inf)
      spec_dec[FLAG_ZERO] = 1'b1;
  end

  assign sp_sign = spec_q[FLAG_NAN] ? 1'b0 : sign_q;
  assign sp_expo = spec_q[FLAG_ZERO] ? '0 : '1;
  assign sp_frac = spec_q[FLAG_NAN] ? QNAN_FRAC : '0;

  fp_pack #(.EXP(EXP), .FRA(FRA)) u_pack_spec (
    .sign (sp_sign), .expo (sp_expo), .frac (sp_frac), .y (spec_y)
  );

  assign e_base = EW'(ea_q) + EW'(LBIAS) - EW'(eb_q);

  fdiv_round #(.EXP(EXP), .FRA(FRA)) u_round (
    .sign   (sign_q),
    .quo    (quo_q),
    .rem    (rem_q),
    .e_base (e_base),
    .y      (rnd_y),
    .flag   (rnd_flag)
  );

  assign q_bit   = (rem_q >= {1'b0, mb_q});
  assign rem_sub = q_bit ? (rem_q - {1'b0, mb_q}) : rem_q;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    mb_d    = mb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    spec_d  = spec_q;
    y_d     = y_q;
    flag_d  = flag_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d  = a_sign ^ b_sign;
          ea_d    = a_expo;
          eb_d    = b_expo;
          mb_d    = {1'b1, b_frac};
          rem_d   = {2'b01, a_frac};
          quo_d   = '0;
          cnt_d   = '0;
          spec_d  = spec_dec;
          state_d = (|spec_dec) ? ST_SPEC : ST_DIV;
        end
      end
      ST_SPEC: begin
        // Result is registered on the first cycle, presented on the next
        if (cnt_q == '0) begin
          y_d    = spec_y;
          flag_d = spec_q;
          cnt_d  = CW'(1);
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DIV: begin
        quo_d = {quo_q[QW-2:0], q_bit};
        rem_d = rem_sub << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LITER - 1))
          state_d = ST_NORM;
      end
      ST_NORM: begin
        y_d     = rnd_y;
        flag_d  = rnd_flag;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge aresetn) begin
    if (aresetn) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      ea_q        <= '0;
      eb_q        <= '0;
      mb_q        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      spec_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      flag_q      <= '0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      ea_q        <= ea_d;
      eb_q        <= eb_d;
      mb_q        <= mb_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      spec_q      <= spec_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      flag_q      <= flag_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Y         = y_q;
  assign flag      = flag_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_fdiv.sv
// ---------------------------------------------------------------------------
// tb_seq_fdiv : directed self-checking bench for seq_fdiv (half precision)
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_fdiv;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y_out;
  logic [2:0]  flag_out;

  int checks = 0;
  int errors = 0;

  seq_fdiv #(.EXP(5), .FRA(10)) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (y_out),
    .flag      (flag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issues one operation and checks latency (edges after accept), Y and flag
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ey, input logic [2:0] ef, input int elat);
    int n;
    @(negedge clk);
    check({tag, " rdy"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " lat"}, n, elat);
    check({tag, " y"}, {16'd0, y_out}, {16'd0, ey});
    check({tag, " flag"}, {29'd0, flag_out}, {29'd0, ef});
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    aresetn   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst y", {16'd0, y_out}, 32'd0);
    check("rst flag", {29'd0, flag_out}, 32'd0);
    @(negedge clk);
    aresetn = 1'b0;
    @(posedge clk);
    #1;
    check("idle in_ready", {31'd0, in_ready}, 32'd1);

    do_op("6/3",    16'h4600, 16'h4200, 16'h4000, 3'b000, 15);
    do_op("1/3",    16'h3C00, 16'h4200, 16'h3555, 3'b000, 15);
    do_op("-6/3",   16'hC600, 16'h4200, 16'hC000, 3'b000, 15);
    do_op("1/5",    16'h3C00, 16'h4500, 16'h3266, 3'b000, 15);
    do_op("10/3",   16'h4900, 16'h4200, 16'h42AB, 3'b000, 15);
    do_op("1/0",    16'h3C00, 16'h0000, 16'h7C00, 3'b010, 2);
    do_op("0/0",    16'h0000, 16'h0000, 16'h7E00, 3'b100, 2);
    do_op("0/2",    16'h0000, 16'h4000, 16'h0000, 3'b001, 2);
    do_op("inf/inf",16'h7C00, 16'h7C00, 16'h7E00, 3'b100, 2);
    do_op("-2/inf", 16'hC000, 16'h7C00, 16'h8000, 3'b001, 2);
    do_op("-inf/2", 16'hFC00, 16'h4000, 16'hFC00, 3'b010, 2);
    do_op("sub/2",  16'h0001, 16'h4000, 16'h0000, 3'b001, 2);
    do_op("ovf",    16'h7BFF, 16'h1400, 16'h7C00, 3'b010, 15);
    do_op("unf",    16'h0400, 16'h7800, 16'h0000, 3'b001, 15);

    // Backpressure: result must hold while out_ready stays low
    out_ready = 1'b0;
    do_op("bp", 16'h4900, 16'h4200, 16'h42AB, 3'b000, 15);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp hold valid", {31'd0, out_valid}, 32'd1);
      check("bp hold y", {16'd0, y_out}, 32'h42AB);
      check("bp hold flag", {29'd0, flag_out}, 32'd0);
      check("bp hold in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release valid", {31'd0, out_valid}, 32'd0);
    check("bp release in_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of the divide loop
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = 16'h4600;
    b_in     = 16'h4200;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    aresetn = 1'b1;
    #1;
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst y", {16'd0, y_out}, 32'd0);
    @(negedge clk);
    aresetn = 1'b0;
    @(posedge clk);
    #1;
    check("midrst idle", {31'd0, in_ready}, 32'd1);
    check("midrst no output", {31'd0, out_valid}, 32'd0);
    do_op("post-rst 1/3", 16'h3C00, 16'h4200, 16'h3555, 3'b000, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
